// File: rtl/iob2axi_wr_multi_pkg.sv
// rtl/iob2axi_wr_multi_pkg.sv - shared FSM encoding, AXI widths and AXI constants for iob2axi_wr_multi
package iob2axi_wr_multi_pkg;

   // AXI channel field widths
   localparam int AXI_ID_W    = 1;
   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_LOCK_W  = 1;
   localparam int AXI_CACHE_W = 4;
   localparam int AXI_PROT_W  = 3;
   localparam int AXI_QOS_W   = 4;
   localparam int AXI_RESP_W  = 2;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Constant AXI attributes driven on every burst
   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_VAL  = 4'd2;
   localparam logic [AXI_PROT_W-1:0]  AXI_PROT_VAL   = 3'd2;
   localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

   // Number of byte-offset bits inside one data word
   function automatic int byte_off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/iob2axi_wr_multi_blen.sv
// rtl/iob2axi_wr_multi_blen.sv - combinational burst length calculator (4 KB limit under IOB2AXI_WR_MULTI_4K_EN)
module iob2axi_wr_multi_blen
   import iob2axi_wr_multi_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int LEN_W         = 16,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic [ADDR_W-1:0]                addr,
   input  logic [LEN_W-1:0]                 rem,
   output logic [$clog2(MAX_BURST_LEN):0]   beats
);

   localparam int CNT_W = $clog2(MAX_BURST_LEN) + 1;
   localparam int OFF_W = byte_off_w(DATA_W);
   localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST_LEN);

   // Only the in-page offset matters; the upper address bits are intentionally ignored
   logic unused_addr;
   assign unused_addr = ^addr;

`ifdef IOB2AXI_WR_MULTI_4K_EN
   // Words left before the next 4 KB page; addr is word aligned so this is exact and >= 1
   logic [12:0] page_left;
   assign page_left = (13'd4096 - {1'b0, addr[11:0]}) >> OFF_W;
`endif

   // Burst length is the smallest of the remaining words, the burst cap and the page room
   always_comb begin
      if (rem >= LEN_W'(MAX_BURST_LEN)) begin
         beats = MAX_B;
      end else begin
         beats = CNT_W'(rem);
      end
`ifdef IOB2AXI_WR_MULTI_4K_EN
      if (page_left < 13'(beats)) begin
         beats = CNT_W'(page_left);
      end
`endif
   end

endmodule

// File: rtl/iob2axi_wr_multi.sv
// rtl/iob2axi_wr_multi.sv - native-to-AXI4 multi-burst write DMA engine (4 KB guard: IOB2AXI_WR_MULTI_4K_EN)
module iob2axi_wr_multi
   import iob2axi_wr_multi_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int LEN_W         = 16,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic                    clk,
   input  logic                    rst,

   // command port
   input  logic                    run,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [LEN_W-1:0]        length,
   output logic                    ready,
   output logic                    error,

   // native write data port
   input  logic                    s_valid,
   input  logic [DATA_W-1:0]       s_wdata,
   input  logic [DATA_W/8-1:0]     s_wstrb,
   output logic                    s_ready,

   // AXI AW channel
   output logic [AXI_ID_W-1:0]     m_axi_awid,
   output logic [ADDR_W-1:0]       m_axi_awaddr,
   output logic [AXI_LEN_W-1:0]    m_axi_awlen,
   output logic [AXI_SIZE_W-1:0]   m_axi_awsize,
   output logic [AXI_BURST_W-1:0]  m_axi_awburst,
   output logic [AXI_LOCK_W-1:0]   m_axi_awlock,
   output logic [AXI_CACHE_W-1:0]  m_axi_awcache,
   output logic [AXI_PROT_W-1:0]   m_axi_awprot,
   output logic [AXI_QOS_W-1:0]    m_axi_awqos,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,

   // AXI W channel
   output logic [AXI_ID_W-1:0]     m_axi_wid,
   output logic [DATA_W-1:0]       m_axi_wdata,
   output logic [DATA_W/8-1:0]     m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,

   // AXI B channel
   input  logic [AXI_RESP_W-1:0]   m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready
);

   localparam int CNT_W = $clog2(MAX_BURST_LEN) + 1;
   localparam int OFF_W = byte_off_w(DATA_W);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

   logic [1:0]         state;
   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W-1:0]   rem_q;
   logic [CNT_W-1:0]   beats;
   logic [CNT_W-1:0]   beats_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               in_data;
   logic               w_hs;

   // Beat count of the burst about to be issued from the current address and remainder
   iob2axi_wr_multi_blen #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .LEN_W         (LEN_W),
      .MAX_BURST_LEN (MAX_BURST_LEN)
   ) blen (
      .addr  (addr_q),
      .rem   (rem_q),
      .beats (beats)
   );

   // Fixed AXI attributes
   assign m_axi_awid    = '0;
   assign m_axi_wid     = '0;
   assign m_axi_awsize  = AXI_SIZE_W'(OFF_W);
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = '0;
   assign m_axi_awcache = AXI_CACHE_VAL;
   assign m_axi_awprot  = AXI_PROT_VAL;
   assign m_axi_awqos   = '0;

   // addr_q and rem_q are frozen in ADDR, so awaddr/awlen hold steady until awready
   assign ready         = (state == ST_IDLE);
   assign m_axi_awvalid = (state == ST_ADDR);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = AXI_LEN_W'(beats - CNT_W'(1));

   // W is a straight pass-through of the native port, gated to the DATA phase
   assign in_data       = (state == ST_DATA);
   assign m_axi_wvalid  = in_data & s_valid;
   assign s_ready       = in_data & m_axi_wready;
   assign m_axi_wdata   = s_wdata;
   assign m_axi_wstrb   = s_wstrb;
   assign m_axi_wlast   = in_data & (cnt_q == CNT_W'(1));
   assign w_hs          = m_axi_wvalid & m_axi_wready;

   assign m_axi_bready  = (state == ST_RESP);

   // Command latch, per-burst bookkeeping and the IDLE/ADDR/DATA/RESP sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         beats_q <= '0;
         cnt_q   <= '0;
         error   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run && (length != '0)) begin
                  addr_q <= addr & ALIGN_MASK;
                  rem_q  <= length;
                  error  <= 1'b0;
                  state  <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_axi_awready) begin
                  beats_q <= beats;
                  cnt_q   <= beats;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     // address wraps naturally at 2^ADDR_W
                     addr_q <= addr_q + (ADDR_W'(beats_q) << OFF_W);
                     rem_q  <= rem_q - LEN_W'(beats_q);
                     state  <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (m_axi_bvalid) begin
                  // a bad response is recorded but the remaining bursts still go out
                  if (m_axi_bresp != AXI_RESP_OKAY) begin
                     error <= 1'b1;
                  end
                  state <= (rem_q != '0) ? ST_ADDR : ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iob2axi_wr_multi.sv
// tb/tb_iob2axi_wr_multi.sv - self-checking bench for iob2axi_wr_multi (follows IOB2AXI_WR_MULTI_4K_EN)
`timescale 1ns/1ps
module tb_iob2axi_wr_multi;

   localparam int ADDR_W        = 32;
   localparam int DATA_W        = 32;
   localparam int LEN_W         = 16;
   localparam int MAX_BURST_LEN = 16;
   localparam int BYTES         = DATA_W / 8;
   localparam int BUDGET        = 3000;
`ifdef IOB2AXI_WR_MULTI_4K_EN
   localparam bit PAGE_EN = 1'b1;
`else
   localparam bit PAGE_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                run = 1'b0;
   logic [ADDR_W-1:0]   addr = '0;
   logic [LEN_W-1:0]    length = '0;
   logic                ready, error;
   logic                s_valid = 1'b0;
   logic [DATA_W-1:0]   s_wdata = '0;
   logic [BYTES-1:0]    s_wstrb = '0;
   logic                s_ready;
   logic [0:0]          m_axi_awid;
   logic [ADDR_W-1:0]   m_axi_awaddr;
   logic [7:0]          m_axi_awlen;
   logic [2:0]          m_axi_awsize;
   logic [1:0]          m_axi_awburst;
   logic [0:0]          m_axi_awlock;
   logic [3:0]          m_axi_awcache;
   logic [2:0]          m_axi_awprot;
   logic [3:0]          m_axi_awqos;
   logic                m_axi_awvalid;
   logic                m_axi_awready = 1'b0;
   logic [0:0]          m_axi_wid;
   logic [DATA_W-1:0]   m_axi_wdata;
   logic [BYTES-1:0]    m_axi_wstrb;
   logic                m_axi_wlast, m_axi_wvalid;
   logic                m_axi_wready = 1'b0;
   logic [1:0]          m_axi_bresp = 2'b00;
   logic                m_axi_bvalid = 1'b0;
   logic                m_axi_bready;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iob2axi_wr_multi #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST_LEN(MAX_BURST_LEN)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .addr(addr), .length(length),
      .ready(ready), .error(error),
      .s_valid(s_valid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   typedef struct {
      logic [31:0] a;
      int len;
      int aw_delay;
      int wmode;      // 0 always ready, 1 toggling, 2 random
      int gap;        // percent of cycles with s_valid low
      int err_burst;  // burst index answered with SLVERR, -1 none
      int exp_nb;     // expected burst count
      int exp_err;    // expected error flag at completion
   } vec_t;

   vec_t vecs[11];

   logic [31:0] exp_addr[$];
   int          exp_len[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Reference burst list: walk the transfer word by word-chunk with plain arithmetic
   task automatic build_model(input logic [31:0] a_in, input int len);
      longint a;
      int left, b, page;
      exp_addr.delete();
      exp_len.delete();
      a = (longint'(a_in) / BYTES) * BYTES;
      left = len;
      while (left > 0) begin
         b = (left < MAX_BURST_LEN) ? left : MAX_BURST_LEN;
         if (PAGE_EN) begin
            page = int'((4096 - (a % 4096)) / BYTES);
            if (page < b) b = page;
         end
         exp_addr.push_back(32'(a));
         exp_len.push_back(b);
         a = (a + longint'(b * BYTES)) % (longint'(1) << 32);
         left -= b;
      end
   endtask

   function automatic logic [31:0] data_of(input int seed, input int i);
      return {16'(seed), 16'(i)} ^ 32'h5A5A_3C3C;
   endfunction

   function automatic logic [3:0] strb_of(input int seed, input int i);
      return 4'(i + seed);
   endfunction

   task automatic run_xfer(input logic [31:0] a, input int len, input int aw_delay, input int wmode,
                           input int gap, input int err_burst, input int exp_nb, input int exp_err,
                           input int abort_at);
      int nb, aw_cnt, w_cnt, b_cnt, w_b, w_in_b, aw_wait, src_idx, seed, model_err;
      bit b_pend, after_b, proto_bad, aw_pend, done, tog;
      logic [31:0] prev_addr;
      logic [7:0]  prev_len;
      build_model(a, len);
      nb = exp_addr.size();
      model_err = (err_burst >= 0 && err_burst < nb) ? 1 : 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; w_b = 0; w_in_b = 0; aw_wait = 0; src_idx = 0;
      b_pend = 0; after_b = 0; proto_bad = 0; aw_pend = 0; done = 0; tog = 0;
      prev_addr = '0; prev_len = '0;
      seed = int'($urandom_range(0, 65535));

      @(negedge clk);
      run = 1'b1; addr = a; length = LEN_W'(len);
      s_valid = 1'b0; m_axi_bvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      check("start_awvalid", m_axi_awvalid, 1);
      check("start_ready", ready, 0);
      check("start_error_clr", error, 0);

      for (int it = 0; it < BUDGET; it++) begin
         if (after_b) begin
            after_b = 0;
            if (b_cnt < nb) check("next_aw_latency", m_axi_awvalid, 1);
            else            check("ready_latency", ready, 1);
         end
         if (ready) begin
            done = 1;
            break;
         end
         if (abort_at > 0 && w_cnt == abort_at) begin
            s_valid = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
            #1;
            check("pre_rst_wvalid", m_axi_wvalid, 1);
            rst = 1'b1;
            #1;
            check("rst_ready", ready, 1);
            check("rst_awvalid", m_axi_awvalid, 0);
            check("rst_wvalid", m_axi_wvalid, 0);
            check("rst_wlast", m_axi_wlast, 0);
            check("rst_bready", m_axi_bready, 0);
            check("rst_s_ready", s_ready, 0);
            check("rst_error", error, 0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0; s_valid = 1'b0;
            return;
         end

         // drive this cycle's inputs
         s_valid = (src_idx < len) && (int'($urandom_range(0, 99)) >= gap);
         s_wdata = data_of(seed, src_idx);
         s_wstrb = strb_of(seed, src_idx);
         m_axi_awready = (aw_wait >= aw_delay);
         case (wmode)
            0: m_axi_wready = 1'b1;
            1: begin tog = !tog; m_axi_wready = tog; end
            default: m_axi_wready = 1'($urandom_range(0, 1));
         endcase
         m_axi_bvalid = b_pend;
         m_axi_bresp  = (b_pend && b_cnt == err_burst) ? 2'b10 : 2'b00;
         #1;

         // observe handshakes that the next rising edge will complete
         if (m_axi_awvalid && m_axi_wvalid) proto_bad = 1;
         if (m_axi_bready && m_axi_wvalid) proto_bad = 1;
         if (m_axi_wvalid && (s_ready != m_axi_wready)) proto_bad = 1;
         if (m_axi_awvalid) begin
            if (aw_pend && (m_axi_awaddr != prev_addr || m_axi_awlen != prev_len)) proto_bad = 1;
            if (m_axi_awready) begin
               if (aw_cnt < nb) begin
                  check("awaddr", m_axi_awaddr, exp_addr[aw_cnt]);
                  check("awlen", m_axi_awlen, exp_len[aw_cnt] - 1);
               end else begin
                  proto_bad = 1;
               end
               aw_cnt++; aw_pend = 0; aw_wait = 0;
            end else begin
               aw_pend = 1; prev_addr = m_axi_awaddr; prev_len = m_axi_awlen; aw_wait++;
            end
         end
         if (s_valid && s_ready) src_idx++;
         if (m_axi_wvalid && m_axi_wready) begin
            if (w_b < nb) begin
               check("wdata", m_axi_wdata, data_of(seed, w_cnt));
               check("wstrb", m_axi_wstrb, strb_of(seed, w_cnt));
               check("wlast", m_axi_wlast, (w_in_b + 1 == exp_len[w_b]));
               w_in_b++;
               if (w_in_b == exp_len[w_b]) begin
                  w_b++; w_in_b = 0; b_pend = 1;
               end
            end else begin
               proto_bad = 1;
            end
            w_cnt++;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            b_cnt++; b_pend = 0; after_b = 1;
         end
         @(posedge clk);
         @(negedge clk);
      end

      s_valid = 1'b0; m_axi_bvalid = 1'b0;
      check("completed", done, 1);
      check("aw_count", aw_cnt, nb);
      check("w_count", w_cnt, len);
      check("b_count", b_cnt, nb);
      check("error_flag", error, model_err);
      check("protocol", proto_bad, 0);
      if (exp_nb >= 0)  check("tbl_bursts", aw_cnt, exp_nb);
      if (exp_err >= 0) check("tbl_error", error, exp_err);
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0100,  4, 0, 0,  0, -1, 1, 0};
      vecs[1]  = '{32'h0000_0000, 40, 0, 0,  0, -1, 3, 0};
      vecs[2]  = '{32'h0000_0FF8,  8, 0, 0,  0, -1, PAGE_EN ? 2 : 1, 0};
      vecs[3]  = '{32'h0000_0040, 37, 3, 1, 30, -1, 3, 0};
      vecs[4]  = '{32'h0000_2000, 48, 0, 0,  0,  1, 3, 1};
      vecs[5]  = '{32'h0000_1000,  1, 0, 0,  0, -1, 1, 0};
      vecs[6]  = '{32'h0000_0500, 16, 1, 0,  0, -1, 1, 0};
      vecs[7]  = '{32'h0000_0600, 17, 0, 1,  0, -1, 2, 0};
      vecs[8]  = '{32'h0000_010B,  3, 0, 0,  0, -1, 1, 0};
      vecs[9]  = '{32'hFFFF_FFF0,  8, 0, 0,  0, -1, PAGE_EN ? 2 : 1, 0};
      vecs[10] = '{32'h0000_3000, 33, 2, 2, 50,  2, 3, 1};

      // reset state with active-looking inputs
      rst = 1'b1; s_valid = 1'b1; m_axi_wready = 1'b1; m_axi_awready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_ready", ready, 1);
      check("reset_error", error, 0);
      check("reset_awvalid", m_axi_awvalid, 0);
      check("reset_wvalid", m_axi_wvalid, 0);
      check("reset_wlast", m_axi_wlast, 0);
      check("reset_bready", m_axi_bready, 0);
      check("reset_s_ready", s_ready, 0);
      check("awsize", m_axi_awsize, 2);
      check("awburst", m_axi_awburst, 1);
      check("awcache", m_axi_awcache, 2);
      check("awprot", m_axi_awprot, 2);
      check("awqos", m_axi_awqos, 0);
      check("awlock", m_axi_awlock, 0);
      check("ids", {m_axi_awid, m_axi_wid}, 0);
      rst = 1'b0; s_valid = 1'b0;

      for (int i = 0; i < 5; i++)
         run_xfer(vecs[i].a, vecs[i].len, vecs[i].aw_delay, vecs[i].wmode, vecs[i].gap,
                  vecs[i].err_burst, vecs[i].exp_nb, vecs[i].exp_err, 0);

      // zero-length command is ignored and leaves the sticky error alone
      @(negedge clk);
      run = 1'b1; addr = 32'h700; length = '0;
      @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      check("len0_ready", ready, 1);
      check("len0_awvalid", m_axi_awvalid, 0);
      check("len0_error_kept", error, 1);

      for (int i = 5; i < 11; i++)
         run_xfer(vecs[i].a, vecs[i].len, vecs[i].aw_delay, vecs[i].wmode, vecs[i].gap,
                  vecs[i].err_burst, vecs[i].exp_nb, vecs[i].exp_err, 0);

      // reset in the middle of a burst, then a clean restart
      run_xfer(32'h200, 16, 0, 0, 0, -1, -1, -1, 4);
      run_xfer(32'h300, 4, 0, 0, 0, -1, 1, 0, 0);

      for (int r = 0; r < 20; r++) begin
         logic [31:0] ra;
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
         run_xfer(ra, int'($urandom_range(1, 70)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 50)),
                  int'($urandom_range(0, 5)) - 1, -1, -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
